// File: rtl/spi_master_pkg.sv
// Shared types and constants for the same-clock SPI master.
// Frame layout: {op[1], op[1], op[0], data[7:0]}, sent MSB first.
package spi_master_pkg;

   typedef enum logic [2:0] {
      M_IDLE,
      M_START,
      M_SHIFT,
      M_HOLD,
      M_TURN,
      M_RECV,
      M_GAP
   } mstate_e;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam int FRAME_BITS = 11;
   localparam int RX_BITS    = 8;

   // Leading copy of op[1] is the slave's command/data selector bit.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] op,
                                                        input logic [7:0] data);
      return {op[1], op, data};
   endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// TX parallel-load shift register and RX capture shift register, both MSB first.
// rx_next exposes the RX value including the current MISO bit so the final bit can be captured in the same edge.
module spi_master_shifter
   import spi_master_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] load_frame,
   input  logic                  shift,
   input  logic                  capture,
   input  logic                  miso_bit,
   output logic                  tx_msb,
   output logic [RX_BITS-1:0]    rx_next
);

   logic [FRAME_BITS-1:0] tx_sr;
   logic [RX_BITS-1:0]    rx_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr <= '0;
         rx_sr <= '0;
      end else begin
         if (load) begin
            tx_sr <= load_frame;
         end else if (shift) begin
            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
         end
         if (capture) begin
            rx_sr <= rx_next;
         end
      end
   end

   assign tx_msb  = tx_sr[FRAME_BITS-1];
   assign rx_next = {rx_sr[RX_BITS-2:0], miso_bit};

endmodule

// File: rtl/spi_master_ctrl.sv
// Same-clock SPI master: one command in flight, frames SS_n/MOSI and captures MISO for RD_DATA.
// Outputs are registered from the next state so they line up with the state they describe.
module spi_master_ctrl
   import spi_master_pkg::*;
#(
   parameter int HOLD_CYC = 2,
   parameter int TURN_CYC = 2,
   parameter int GAP_CYC  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam int WMAX = (HOLD_CYC > TURN_CYC) ?
                         ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC) :
                         ((TURN_CYC > GAP_CYC) ? TURN_CYC : GAP_CYC);
   localparam int WW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

   localparam logic [WW-1:0] HOLD_TC = WW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
   localparam logic [WW-1:0] TURN_TC = WW'(TURN_CYC - 1);
   localparam logic [WW-1:0] GAP_TC  = WW'(GAP_CYC - 1);

   mstate_e        state;
   mstate_e        next;
   logic [3:0]     bit_cnt;
   logic [WW-1:0]  wait_cnt;
   logic [WW-1:0]  wait_tc;
   logic [1:0]     op_q;
   logic           accept;
   logic           bit_last;
   logic           wait_last;
   logic           tx_msb;
   logic [7:0]     rx_next;

   assign cmd_ready = (state == M_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   spi_master_shifter u_shifter (
      .clk        (clk),
      .rst        (rst),
      .load       (accept),
      .load_frame (build_frame(cmd_op, cmd_data)),
      .shift      (next == M_SHIFT),
      .capture    (state == M_RECV),
      .miso_bit   (MISO),
      .tx_msb     (tx_msb),
      .rx_next    (rx_next)
   );

   always_comb begin
      wait_tc = GAP_TC;
      next    = state;
      case (state)
         M_HOLD:  wait_tc = HOLD_TC;
         M_TURN:  wait_tc = TURN_TC;
         default: wait_tc = GAP_TC;
      endcase
      // bit_cnt is shared between the TX shift and the RX capture phases.
      bit_last  = (state == M_RECV) ? (bit_cnt == 4'(RX_BITS - 1))
                                    : (bit_cnt == 4'(FRAME_BITS - 1));
      wait_last = (wait_cnt == wait_tc);
      case (state)
         M_IDLE:  if (accept) next = M_START;
         M_START: next = M_SHIFT;
         M_SHIFT: begin
            if (bit_last) begin
               if (op_q == OP_RD_DATA) next = M_TURN;
               else if (HOLD_CYC == 0) next = M_GAP;
               else                    next = M_HOLD;
            end
         end
         M_HOLD:  if (wait_last) next = M_GAP;
         M_TURN:  if (wait_last) next = M_RECV;
         M_RECV:  if (bit_last)  next = M_GAP;
         M_GAP:   if (wait_last) next = M_IDLE;
         default: next = M_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= M_IDLE;
         bit_cnt   <= '0;
         wait_cnt  <= '0;
         op_q      <= OP_WR_ADDR;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state <= next;
         if (accept) op_q <= cmd_op;
         if (state == M_SHIFT || state == M_RECV) begin
            bit_cnt <= bit_last ? 4'd0 : bit_cnt + 4'd1;
         end
         if (state == M_HOLD || state == M_TURN || state == M_GAP) begin
            wait_cnt <= wait_last ? '0 : wait_cnt + WW'(1);
         end
         SS_n      <= (next == M_IDLE) || (next == M_GAP);
         MOSI      <= (next == M_SHIFT) && tx_msb;
         busy      <= (next != M_IDLE);
         rsp_valid <= (state == M_RECV) && bit_last;
         if (state == M_RECV && bit_last) rsp_data <= rx_next;
      end
   end

endmodule
